// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers that size the logical framebuffer
// from the selected logical resolution.
package vga_pkg;
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int CNT_W   = 10;

    // hires = 320x240 (2x2 blocks); otherwise 160x120 (4x4 blocks)
    function automatic int scale_shift(input bit hires);
        return hires ? 1 : 2;
    endfunction

    function automatic int coord_x_w(input bit hires);
        return hires ? 9 : 8;
    endfunction

    function automatic int coord_y_w(input bit hires);
        return hires ? 8 : 7;
    endfunction

    function automatic int fb_addr_w(input bit hires);
        return hires ? 17 : 15;
    endfunction
endpackage

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel tick at clock/2, beam counters, raw syncs
// and the logical scan coordinate of the current beam position.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int SHIFT = 2,
    parameter int XW    = 8,
    parameter int YW    = 7
) (
    input  logic          clock,
    input  logic          reset_n,
    output logic          tick,
    output logic          hs,
    output logic          vs,
    output logic          blank_n,
    output logic [XW-1:0] scan_x,
    output logic [YW-1:0] scan_y
);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic             toggle;
    logic [CNT_W-1:0] hcount, vcount;
    logic             h_vis, v_vis;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            toggle <= 1'b0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            toggle <= ~toggle;
            if (toggle) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
                end else begin
                    hcount <= hcount + CNT_W'(1);
                end
            end
        end
    end

    assign tick    = toggle;
    assign hs      = !(hcount >= HS_START && hcount < HS_END);
    assign vs      = !(vcount >= VS_START && vcount < VS_END);
    assign h_vis   = hcount < CNT_W'(H_VIS);
    assign v_vis   = vcount < CNT_W'(V_VIS);
    assign blank_n = h_vis && v_vis;

    // Parked at (0,0) outside the visible area so the read address never leaves the buffer
    assign scan_x = blank_n ? XW'(hcount >> SHIFT) : '0;
    assign scan_y = blank_n ? YW'(vcount >> SHIFT) : '0;
endmodule

// File: rtl/vga_pixel_adapter.sv
// Framebuffered 640x480@60 VGA output stage: single-pixel writes at logical
// resolution, each logical pixel scanned out as a square block.
module vga_pixel_adapter
    import vga_pkg::*;
#(
    parameter string RESOLUTION              = "160x120",
    parameter string MONOCHROME              = "FALSE",
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    parameter string BACKGROUND_IMAGE        = "black.mif",
    localparam bit   HIRES = (RESOLUTION == "320x240"),
    localparam bit   MONO  = (MONOCHROME == "TRUE"),
    localparam int   B     = BITS_PER_COLOUR_CHANNEL,
    localparam int   CW    = MONO ? B : 3 * B,
    localparam int   XW    = coord_x_w(HIRES),
    localparam int   YW    = coord_y_w(HIRES)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [CW-1:0] colour,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic          plot,
    output logic [9:0]    VGA_R,
    output logic [9:0]    VGA_G,
    output logic [9:0]    VGA_B,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK,
    output logic          VGA_SYNC,
    output logic          VGA_CLK
);
    localparam int SHIFT = scale_shift(HIRES);
    localparam int LW    = H_VIS >> SHIFT;
    localparam int LH    = V_VIS >> SHIFT;
    localparam int AW    = fb_addr_w(HIRES);
    localparam int DEPTH = LW * LH;
    localparam int REPS  = (10 + B - 1) / B;
    localparam logic [XW-1:0] X_LAST = XW'(LW - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(LH - 1);

    // LW is 160 or 320, i.e. two powers of two: y*LW as a sum of shifts
    function automatic logic [AW-1:0] fb_addr(input logic [XW-1:0] px, input logic [YW-1:0] py);
        return (AW'(py) << (9 - SHIFT)) + (AW'(py) << (7 - SHIFT)) + AW'(px);
    endfunction

    logic          tick, hs_raw, vs_raw, blank_raw;
    logic [XW-1:0] scan_x;
    logic [YW-1:0] scan_y;

    vga_timing_gen #(.SHIFT(SHIFT), .XW(XW), .YW(YW)) u_timing (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (tick),
        .hs      (hs_raw),
        .vs      (vs_raw),
        .blank_n (blank_raw),
        .scan_x  (scan_x),
        .scan_y  (scan_y)
    );

    (* ram_init_file = BACKGROUND_IMAGE *) logic [CW-1:0] mem [DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [CW-1:0] rd_data;
    logic          hs_d, vs_d, blank_d;
    logic [9:0]    chan [3];

    // Out-of-range coordinates are dropped rather than wrapped into the buffer
    assign wr_en   = plot && (x <= X_LAST) && (y <= Y_LAST);
    assign wr_addr = fb_addr(x, y);
    assign rd_addr = fb_addr(scan_x, scan_y);

    // Writes ignore reset; a same-cycle read of the same word sees the old data
    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= colour;
    end

    for (genvar c = 0; c < 3; c++) begin : g_chan
        localparam int SRC = MONO ? 0 : 2 - c;
        logic [REPS*B-1:0] rep;
        assign rep     = {REPS{rd_data[SRC*B +: B]}};
        assign chan[c] = rep[REPS*B-1 -: 10];
    end

    // Two tick stages: RAM read, then colour/blank merge; syncs ride alongside
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_data   <= '0;
            hs_d      <= 1'b1;
            vs_d      <= 1'b1;
            blank_d   <= 1'b0;
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
        end else if (tick) begin
            rd_data   <= mem[rd_addr];
            hs_d      <= hs_raw;
            vs_d      <= vs_raw;
            blank_d   <= blank_raw;
            VGA_HS    <= hs_d;
            VGA_VS    <= vs_d;
            VGA_BLANK <= blank_d;
            VGA_R     <= blank_d ? chan[0] : '0;
            VGA_G     <= blank_d ? chan[1] : '0;
            VGA_B     <= blank_d ? chan[2] : '0;
        end
    end

    assign VGA_SYNC = 1'b1;
    assign VGA_CLK  = tick;
endmodule

// File: tb/tb_vga_pixel_adapter.sv
// Directed bench for vga_pixel_adapter: reset state, one full frame of raster
// and pixel checks, mid-line reset restart and a vertical-blank write.
module tb_vga_pixel_adapter;
    localparam logic [31:0] BLACK = 32'h0000_0000;
    localparam logic [31:0] RED   = 32'h3FF0_0000;
    localparam logic [31:0] GREEN = 32'h000F_FC00;
    localparam logic [31:0] CYAN  = 32'h000F_FFFF;
    localparam logic [31:0] WHITE = 32'h3FFF_FFFF;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] colour = '0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic       plot = 1'b0;
    logic [9:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank, vga_sync, vga_clk;

    int vectors = 0;
    int errors  = 0;
    int h = 0, v = 0;
    int hs_low = 0, hs_bad = 0, vs_lines = 0, vis = 0, lit = 0, dark_rgb = 0;

    vga_pixel_adapter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .colour    (colour),
        .x         (x),
        .y         (y),
        .plot      (plot),
        .VGA_R     (vga_r),
        .VGA_G     (vga_g),
        .VGA_B     (vga_b),
        .VGA_HS    (vga_hs),
        .VGA_VS    (vga_vs),
        .VGA_BLANK (vga_blank),
        .VGA_SYNC  (vga_sync),
        .VGA_CLK   (vga_clk)
    );

    always #1 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_px(input int px, input int py, input logic [2:0] c);
        x = 8'(px); y = 7'(py); colour = c; plot = 1'b1;
        @(posedge clock); @(negedge clock);
        plot = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_hs"},    32'(vga_hs), 1);
        chk({tag, "_vs"},    32'(vga_vs), 1);
        chk({tag, "_blank"}, 32'(vga_blank), 0);
        chk({tag, "_rgb"},   {2'b00, vga_r, vga_g, vga_b}, BLACK);
        chk({tag, "_clk"},   32'(vga_clk), 0);
    endtask

    // Pixel 0 of line 0 reaches the pins four clocks after release
    task automatic release_reset();
        reset_n = 1'b1;
        @(posedge clock); @(negedge clock);
        chk("vga_clk_rise", 32'(vga_clk), 1);
        @(posedge clock); @(negedge clock);
        chk("vga_clk_fall", 32'(vga_clk), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        h = 0; v = 0;
    endtask

    task automatic next_pixel();
        repeat (2) @(posedge clock);
        @(negedge clock);
        if (h == 799) begin
            h = 0;
            v = (v == 524) ? 0 : v + 1;
        end else begin
            h++;
        end
    endtask

    task automatic observe();
        logic [31:0] rgb;
        rgb = {2'b00, vga_r, vga_g, vga_b};
        if (!vga_hs) hs_low++;
        if (h == 799) begin
            if (hs_low != 96) hs_bad++;
            hs_low = 0;
        end
        if (h == 0 && !vga_vs) vs_lines++;
        if (vga_blank) begin
            vis++;
            if (rgb != 0) lit++;
        end else if (rgb != 0) begin
            dark_rgb++;
        end
        if ((h == 0 || h == 3) && (v == 0 || v == 3)) chk($sformatf("red_%0d_%0d", h, v), rgb, RED);
        if ((h == 4 && v == 0) || (h == 0 && v == 4) || (h == 0 && v == 24) || (h == 8 && v == 0))
            chk($sformatf("black_%0d_%0d", h, v), rgb, BLACK);
        if ((h == 636 && v == 476) || (h == 639 && v == 479)) chk($sformatf("cyan_%0d_%0d", h, v), rgb, CYAN);
        if (h == 635 && v == 476) chk("black_635_476", rgb, BLACK);
        if ((h == 80 && v == 80) || (h == 83 && v == 83)) chk($sformatf("white_%0d_%0d", h, v), rgb, WHITE);
        if (h == 639 && v == 479) chk("blank_639_479", 32'(vga_blank), 1);
        if (h == 640 && v == 479) chk("blank_640_479", 32'(vga_blank), 0);
        if (h == 0 && v == 480)   chk("blank_0_480", 32'(vga_blank), 0);
        if (v == 0 && (h == 655 || h == 752)) chk($sformatf("hs_hi_%0d", h), 32'(vga_hs), 1);
        if (v == 0 && (h == 656 || h == 751)) chk($sformatf("hs_lo_%0d", h), 32'(vga_hs), 0);
        if (h == 0 && (v == 489 || v == 492)) chk($sformatf("vs_hi_%0d", v), 32'(vga_vs), 1);
        if (h == 0 && (v == 490 || v == 491)) chk($sformatf("vs_lo_%0d", v), 32'(vga_vs), 0);
        // Vertical-blank write of logical (2,0) = green, committed on the next step
        if (h == 0 && v == 500) begin
            x = 8'd2; y = 7'd0; colour = 3'b010; plot = 1'b1;
        end else begin
            plot = 1'b0;
        end
    endtask

    initial begin
        // Framebuffer cleared and seeded while held in reset
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                write_px(xx, yy, 3'b000);
        write_px(0, 0, 3'b100);
        write_px(159, 119, 3'b011);
        write_px(20, 20, 3'b111);
        write_px(160, 5, 3'b111);
        write_px(10, 120, 3'b111);
        chk_reset_state("rst0");
        chk("vga_sync", 32'(vga_sync), 1);

        release_reset();
        chk("first_px_red", {2'b00, vga_r, vga_g, vga_b}, RED);
        while (!(v == 10 && h == 300)) next_pixel();

        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_state("rst_mid");
        release_reset();

        for (int n = 0; n < 800 * 525; n++) begin
            if (n > 0) next_pixel();
            observe();
        end
        plot = 1'b0;
        chk("hs_bad_lines", 32'(hs_bad), 0);
        chk("vs_low_lines", 32'(vs_lines), 2);
        chk("visible_px",   32'(vis), 640 * 480);
        chk("lit_px",       32'(lit), 48);
        chk("rgb_in_blank", 32'(dark_rgb), 0);

        next_pixel();
        chk("f1_red_0_0", {2'b00, vga_r, vga_g, vga_b}, RED);
        repeat (8) next_pixel();
        chk("f1_green_8_0", {2'b00, vga_r, vga_g, vga_b}, GREEN);
        repeat (3) next_pixel();
        chk("f1_green_11_0", {2'b00, vga_r, vga_g, vga_b}, GREEN);
        next_pixel();
        chk("f1_black_12_0", {2'b00, vga_r, vga_g, vga_b}, BLACK);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
